// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencing controller.
//   N_POINTS : transform length (64 points)
//   LOG2N    : number of radix-2 stages (6)
//   ADDR_W   : width of every address/counter output (6 bits)
//   N_BFLY   : butterflies per stage (32)
//   fft_state_t : controller state encoding
package fft_pkg;

  localparam int N_POINTS = 64;
  localparam int LOG2N    = 6;
  localparam int ADDR_W   = 6;
  localparam int N_BFLY   = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PROC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } fft_state_t;

endpackage

// File: rtl/fft_ctrl_if.sv
// Handshake and address-generator bus of the FFT controller.
//   master : frame source/sink side (drives start, sample_valid, out_ready)
//   slave  : the controller (drives ready/valid, mode flags, counters,
//            read_bank, write_en, busy)
interface fft_ctrl_if;
  import fft_pkg::*;

  logic              start;
  logic              sample_valid;
  logic              sample_ready;
  logic              out_ready;
  logic              out_valid;
  logic              load;
  logic              processing;
  logic              done;
  logic [ADDR_W-1:0] load_address;
  logic [ADDR_W-1:0] fft_level;
  logic [ADDR_W-1:0] butterfly_iter;
  logic [ADDR_W-1:0] out_address;
  logic              read_bank;
  logic              write_en;
  logic              busy;

  modport master (
    output start, sample_valid, out_ready,
    input  sample_ready, out_valid, load, processing, done,
           load_address, fft_level, butterfly_iter, out_address,
           read_bank, write_en, busy
  );

  modport slave (
    input  start, sample_valid, out_ready,
    output sample_ready, out_valid, load, processing, done,
           load_address, fft_level, butterfly_iter, out_address,
           read_bank, write_en, busy
  );

endinterface

// File: rtl/fft_ctrl_delay_line.sv
// delay_line: single-bit shift register of parameterised depth.
//   clk   : clock
//   rst_n : asynchronous active-low clear of every tap
//   din   : input bit
//   dout  : din delayed by exactly DEPTH cycles (DEPTH >= 1)
module delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] taps_p;

  // stage boundary: one register per cycle of delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_p <= '0;
    end else begin
      taps_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps_p[i] <= taps_p[i-1];
      end
    end
  end

  assign dout = taps_p[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencing controller for an in-place 64-point radix-2 FFT.
// Frame flow: IDLE -> LOAD (64 samples) -> PROC (6 stages x 32 butterflies)
// -> DRAIN (BFLY_LAT cycles) -> OUT (64 bins) -> IDLE.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset, forces IDLE and clears write_en
//   bus     : fft_ctrl_if.slave (start/sample/out handshakes, mode flags,
//             load_address, fft_level, butterfly_iter, out_address,
//             read_bank, write_en, busy)
// Parameter BFLY_LAT (>= 1): butterfly issue-to-write latency in cycles.
// Build option FFT_LEVEL_DRAIN_EN: insert a BFLY_LAT-cycle DRAIN between
// stages so a stage never reads before the previous stage's writes land.
// Without it stages run back-to-back and the datapath relies on bank
// ping-pong via read_bank.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int BFLY_LAT = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  fft_ctrl_if.slave bus
);

  localparam int                DRAIN_W    = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(BFLY_LAT - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W-1:0]  BFLY_LAST  = ADDR_W'(N_BFLY - 1);
  localparam logic [ADDR_W-1:0]  LEVEL_LAST = ADDR_W'(LOG2N - 1);

  fft_state_t         state, state_d;
  logic [ADDR_W-1:0]  load_cnt, load_cnt_d;
  logic [ADDR_W-1:0]  level, level_d;
  logic [ADDR_W-1:0]  iter, iter_d;
  logic [ADDR_W-1:0]  out_cnt, out_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_d;
  // Distinguishes the closing DRAIN (-> OUT) from an inter-stage one (-> PROC).
  logic               final_drain, final_drain_d;
  logic               processing;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      load_cnt    <= '0;
      level       <= '0;
      iter        <= '0;
      out_cnt     <= '0;
      drain_cnt   <= '0;
      final_drain <= 1'b0;
    end else begin
      state       <= state_d;
      load_cnt    <= load_cnt_d;
      level       <= level_d;
      iter        <= iter_d;
      out_cnt     <= out_cnt_d;
      drain_cnt   <= drain_cnt_d;
      final_drain <= final_drain_d;
    end
  end

  always_comb begin
    state_d       = state;
    load_cnt_d    = load_cnt;
    level_d       = level;
    iter_d        = iter;
    out_cnt_d     = out_cnt;
    drain_cnt_d   = drain_cnt;
    final_drain_d = final_drain;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
          level_d    = '0;
          iter_d     = '0;
          out_cnt_d  = '0;
        end
      end
      ST_LOAD: begin
        // sample_ready is constantly high here, so valid alone accepts.
        if (bus.sample_valid) begin
          load_cnt_d = load_cnt + 1'b1;
          if (load_cnt == ADDR_LAST) begin
            state_d = ST_PROC;
          end
        end
      end
      ST_PROC: begin
        iter_d = iter + 1'b1;
        if (iter == BFLY_LAST) begin
          iter_d = '0;
          if (level == LEVEL_LAST) begin
            // Level stays at its terminal value through DRAIN/OUT.
            state_d       = ST_DRAIN;
            drain_cnt_d   = '0;
            final_drain_d = 1'b1;
          end else begin
            level_d = level + 1'b1;
`ifdef FFT_LEVEL_DRAIN_EN
            state_d       = ST_DRAIN;
            drain_cnt_d   = '0;
            final_drain_d = 1'b0;
`endif
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = final_drain ? ST_OUT : ST_PROC;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_cnt_d = out_cnt + 1'b1;
          if (out_cnt == ADDR_LAST) begin
            // Leave IDLE with every counter at zero.
            state_d       = ST_IDLE;
            load_cnt_d    = '0;
            level_d       = '0;
            iter_d        = '0;
            out_cnt_d     = '0;
            final_drain_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign processing = (state == ST_PROC);

  // write_en trails processing by the butterfly latency, regardless of state.
  delay_line #(
    .DEPTH (BFLY_LAT)
  ) u_wr_dly (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (processing),
    .dout  (bus.write_en)
  );

  assign bus.load           = (state == ST_LOAD);
  assign bus.sample_ready   = (state == ST_LOAD);
  assign bus.processing     = processing;
  assign bus.done           = (state == ST_OUT);
  assign bus.out_valid      = (state == ST_OUT);
  assign bus.busy           = (state != ST_IDLE);
  assign bus.load_address   = load_cnt;
  assign bus.fft_level      = level;
  assign bus.butterfly_iter = iter;
  assign bus.out_address    = out_cnt;
  assign bus.read_bank      = level[0];

endmodule

// File: tb/tb_fft_ctrl.sv
`timescale 1ns/1ps
module tb_fft_ctrl;
  import fft_pkg::*;

  localparam int L = 2;
`ifdef FFT_LEVEL_DRAIN_EN
  localparam int GAP = L;
`else
  localparam int GAP = 0;
`endif
  localparam int SLOT   = N_BFLY + GAP;
  localparam int PT     = LOG2N * N_BFLY + (LOG2N - 1) * GAP;
  localparam int BUDGET = 4000;

  typedef logic [31:0] vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fft_ctrl_if bus();

  fft_ctrl #(.BFLY_LAT(L)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: frame phase plus one progress count per phase.
  // ph: 0 idle, 1 load (samples taken), 2 proc timeline (cycles since
  // PROC entry), 3 final drain (cycles), 4 out (bins delivered).
  int   ph = 0;
  int   cnt = 0;
  logic proc_hist[$];

  int cyc = 0;
  int n_proc, n_wr, n_load, n_out, first_proc, last_proc, first_wr;

  function automatic logic m_proc();
    return (ph == 2) && ((cnt % SLOT) < N_BFLY);
  endfunction

  function automatic vec_t expect_vec();
    logic busy, ld, pr, dn, we;
    int la, lv, it, oa;
    busy = (ph != 0); ld = (ph == 1); dn = (ph == 4);
    pr = m_proc(); la = 0; lv = 0; it = 0; oa = 0;
    case (ph)
      1: la = cnt;
      2: begin
        lv = cnt / SLOT;
        if (pr) it = cnt % SLOT;
        else    lv = lv + 1;
      end
      3: lv = LOG2N - 1;
      4: begin lv = LOG2N - 1; oa = cnt; end
      default: ;
    endcase
    we = (proc_hist.size() == L) ? proc_hist[0] : 1'b0;
    return {busy, ld, pr, dn, ld, dn, we, lv[0],
            6'(la), 6'(lv), 6'(it), 6'(oa)};
  endfunction

  function automatic vec_t obs();
    return {bus.busy, bus.load, bus.processing, bus.done, bus.sample_ready,
            bus.out_valid, bus.write_en, bus.read_bank, bus.load_address,
            bus.fft_level, bus.butterfly_iter, bus.out_address};
  endfunction

  task automatic check_vec(input string tag);
    vec_t e, o;
    e = expect_vec();
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o == e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic clear_stats();
    n_proc = 0; n_wr = 0; n_load = 0; n_out = 0;
    first_proc = -1; last_proc = -1; first_wr = -1;
  endtask

  // Advance model with the inputs currently driven, take one clock, check.
  task automatic tick(input string tag);
    proc_hist.push_back(m_proc());
    if (proc_hist.size() > L) void'(proc_hist.pop_front());
    case (ph)
      0: if (bus.start) begin ph = 1; cnt = 0; end
      1: if (bus.sample_valid) begin
           cnt++;
           if (cnt == N_POINTS) begin ph = 2; cnt = 0; end
         end
      2: begin cnt++; if (cnt == PT) begin ph = 3; cnt = 0; end end
      3: begin cnt++; if (cnt == L) begin ph = 4; cnt = 0; end end
      4: if (bus.out_ready) begin
           cnt++;
           if (cnt == N_POINTS) begin ph = 0; cnt = 0; end
         end
      default: ;
    endcase
    @(posedge clk); #1;
    cyc++;
    check_vec(tag);
    if (bus.processing === 1'b1) begin
      n_proc++;
      if (first_proc < 0) first_proc = cyc;
      last_proc = cyc;
    end
    if (bus.write_en === 1'b1) begin
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (bus.load === 1'b1) n_load++;
    if (bus.out_valid === 1'b1) n_out++;
  endtask

  // Pulse reset between edges, check the asynchronous effect, release later.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #2;
    ph = 0; cnt = 0;
    proc_hist.delete();
    check_vec(tag);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int i;
    int stalled_bin;
    logic tog;

    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_state");
    reset_n = 1'b1;
    tick("idle0");
    tick("idle1");

    // Frame 1: continuous samples, out_ready low once at bins 10 and 40,
    // random start pulses while busy.
    clear_stats();
    bus.start = 1'b1;
    tick("f1_start");
    bus.start = 1'b0;
    stalled_bin = -1;
    for (i = 0; i < BUDGET && ph != 0; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.sample_valid = 1'b1;
      bus.out_ready = 1'b1;
      if (ph == 4 && (cnt == 10 || cnt == 40) && stalled_bin != cnt) begin
        bus.out_ready = 1'b0;
        stalled_bin = cnt;
      end
      tick("f1");
    end
    bus.start = 1'b0;
    check_int("f1_budget", int'(i < BUDGET), 1);
    check_int("f1_load_cycles", n_load, 64);
    check_int("f1_proc_cycles", n_proc, 192);
    check_int("f1_write_pulses", n_wr, 192);
    check_int("f1_proc_span", last_proc - first_proc + 1, PT);
    check_int("f1_write_lag", first_wr - first_proc, L);
    check_int("f1_out_cycles", n_out, 66);
    tick("f1_idle");

    // Frame 2: sample_valid toggling 0/1 during LOAD, random out_ready.
    clear_stats();
    bus.start = 1'b1;
    tick("f2_start");
    bus.start = 1'b0;
    tog = 1'b1;
    for (i = 0; i < BUDGET && ph != 0; i++) begin
      if (ph == 1) begin
        tog = ~tog;
        bus.sample_valid = tog;
      end else begin
        bus.sample_valid = 1'($urandom_range(0, 1));
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      tick("f2");
    end
    check_int("f2_budget", int'(i < BUDGET), 1);
    check_int("f2_load_cycles", n_load, 128);
    check_int("f2_write_pulses", n_wr, 192);

    // Frame 3: start held high throughout; a new frame must follow at once.
    clear_stats();
    bus.start = 1'b1;
    tick("f3_start");
    for (i = 0; i < BUDGET && ph != 0; i++) begin
      bus.sample_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick("f3");
    end
    check_int("f3_budget", int'(i < BUDGET), 1);
    tick("f3_restart");
    check_int("f3_restart_load", int'(bus.load === 1'b1), 1);
    bus.start = 1'b0;

    // Frame 4 (already running): reset at fft_level=3, butterfly_iter=17.
    for (i = 0; i < BUDGET && !(ph == 2 && cnt == 3 * SLOT + 17); i++) begin
      bus.sample_valid = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick("f4");
    end
    check_int("f4_budget", int'(i < BUDGET), 1);
    check_int("f4_level_at_reset", int'(bus.fft_level), 3);
    check_int("f4_iter_at_reset", int'(bus.butterfly_iter), 17);
    async_reset("f4_reset_proc");
    clear_stats();
    repeat (L + 2) tick("f4_after_reset");
    check_int("f4_no_stale_write", n_wr, 0);

    // Frame 5: reset in the middle of OUT.
    bus.start = 1'b1;
    tick("f5_start");
    bus.start = 1'b0;
    for (i = 0; i < BUDGET && !(ph == 4 && cnt == 20); i++) begin
      bus.sample_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      tick("f5");
    end
    check_int("f5_budget", int'(i < BUDGET), 1);
    async_reset("f5_reset_out");
    tick("f5_after_reset");

    // Frame 6: reset in the middle of LOAD, then one idle cycle.
    bus.start = 1'b1;
    tick("f6_start");
    bus.start = 1'b0;
    for (i = 0; i < BUDGET && !(ph == 1 && cnt == 30); i++) begin
      bus.sample_valid = 1'($urandom_range(0, 1));
      tick("f6");
    end
    check_int("f6_budget", int'(i < BUDGET), 1);
    async_reset("f6_reset_load");
    tick("f6_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
